cache_fill_ctrl: RTL and testbench

- Controller directly downstream of the 64-set, 2-way cache metadata array.
- Consumes both ways' metadata bytes for the indexed set and performs tag compare to resolve hit/miss.
- Maintains LRU state and drives the metadata write enables and data-in.
- On a miss, picks a victim way and sequences an 8-word block fill from the 4-cycle-latency main memory into the data array.

---
 rtl/cache_fill_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Purpose  : Hit/miss resolution, LRU maintenance and 8-word block fill
//            sequencing for a 64-set, 2-way cache.  Sits directly after the
//            metadata array: it sees both ways' metadata for the indexed set,
//            compares tags, rewrites metadata, and on a miss streams a block
//            from main memory into the data array.
// Ports    :
//   clk            clock, rising-edge
//   rst            asynchronous reset, active low
//   req            access request (held while stall=1)
//   req_addr[15:0] byte address: tag[15:10] index[9:4] offset[3:0]
//   meta0/meta1    {valid, lru, tag[5:0]} of way 0 / way 1 for indexed set
//   mem_data_valid a fill word is on the memory data bus
//   set_enable     one-hot set select for metadata/data arrays
//   meta_din       metadata write value
//   meta_write0/1  metadata write enables for way 0 / way 1
//   hit, hit_way   request hit this cycle and the way that hit
//   stall          requester must hold its request
//   mem_req        memory read issue strobe
//   mem_addr       word-aligned fill address
//   data_write     write current memory word into the data array
//   data_way       fill target way
//   word_sel       word index within the block for data_write
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic [7:0]  meta0,
  input  logic [7:0]  meta1,
  input  logic        mem_data_valid,
  output logic [63:0] set_enable,
  output logic [7:0]  meta_din,
  output logic        meta_write0,
  output logic        meta_write1,
  output logic        hit,
  output logic        hit_way,
  output logic        stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        data_write,
  output logic        data_way,
  output logic [2:0]  word_sel
);

  localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

  // Returns are counted, not timed, so any latency of at least one cycle
  // works; the latency value only documents the memory this was built for.
  if (MEM_LAT < 1) begin : g_lat_unsupported
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  iss_cnt;
  logic [2:0]  rcv_cnt;
  logic        iss_done;
  logic        rcv_done;
  logic [5:0]  lat_tag;
  logic [5:0]  lat_idx;
  logic        victim;

  logic [5:0]  req_tag;
  logic [5:0]  req_idx;
  logic [5:0]  sel_idx;
  logic        match0;
  logic        match1;
  logic        any_match;
  logic        victim_pick;
  logic        unused_bits;

  assign req_tag   = req_addr[15:10];
  assign req_idx   = req_addr[9:4];
  assign match0    = meta0[7] & (meta0[5:0] == req_tag);
  assign match1    = meta1[7] & (meta1[5:0] == req_tag);
  assign any_match = match0 | match1;

  // Fill an invalid way first; otherwise follow the LRU bit held in way 0.
  assign victim_pick = !meta0[7] ? 1'b0 :
                       !meta1[7] ? 1'b1 : meta0[6];

  // During fill/update the arrays must stay on the missing set even if the
  // requester changes or drops its address.
  assign sel_idx    = (state == S_IDLE) ? req_idx : lat_idx;
  assign set_enable = 64'd1 << sel_idx;

  // Byte offset and way-1 LRU bit carry no information for this block.
  assign unused_bits = ^{req_addr[3:0], meta1[6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      iss_cnt  <= 3'd0;
      rcv_cnt  <= 3'd0;
      iss_done <= 1'b0;
      rcv_done <= 1'b0;
      lat_tag  <= 6'd0;
      lat_idx  <= 6'd0;
      victim   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (req && !any_match) begin
            lat_tag  <= req_tag;
            lat_idx  <= req_idx;
            victim   <= victim_pick;
            iss_cnt  <= 3'd0;
            rcv_cnt  <= 3'd0;
            iss_done <= 1'b0;
            rcv_done <= 1'b0;
          end
        end
        S_FILL: begin
          // Issue and receive run independently; each saturates via its
          // done flag instead of wrapping.
          if (!iss_done) begin
            if (iss_cnt == LAST_WORD) iss_done <= 1'b1;
            else                      iss_cnt  <= iss_cnt + 3'd1;
          end
          if (mem_data_valid && !rcv_done) begin
            if (rcv_cnt == LAST_WORD) rcv_done <= 1'b1;
            else                      rcv_cnt  <= rcv_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    meta_din    = 8'd0;
    meta_write0 = 1'b0;
    meta_write1 = 1'b0;
    hit         = 1'b0;
    hit_way     = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = 16'd0;
    data_write  = 1'b0;
    data_way    = 1'b0;
    word_sel    = 3'd0;

    case (state)
      S_IDLE: begin
        // Qualified by rst so every output is quiet while reset is held.
        if (req && rst) begin
          if (any_match) begin
            hit         = 1'b1;
            hit_way     = !match0;
            meta_write0 = 1'b1;
            // Only way 0 stores LRU: hitting way 0 makes way 1 the LRU.
            meta_din    = {meta0[7], !match0 ? 1'b0 : 1'b1, meta0[5:0]};
          end else begin
            stall    = 1'b1;
            state_nx = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall    = 1'b1;
        data_way = victim;
        if (!iss_done) begin
          mem_req  = 1'b1;
          mem_addr = {lat_tag, lat_idx, iss_cnt, 1'b0};
        end
        if (mem_data_valid && !rcv_done) begin
          data_write = 1'b1;
          word_sel   = rcv_cnt;
          if (rcv_cnt == LAST_WORD) state_nx = S_UPDATE;
        end
      end
      S_UPDATE: begin
        stall       = 1'b1;
        meta_din    = {2'b10, lat_tag};
        meta_write0 = !victim;
        meta_write1 = victim;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_ctrl
// Purpose  : Directed bench for cache_fill_ctrl with a 4-cycle memory model,
//            a transaction-level reference model compared every cycle, and
//            hand-computed literal expectations at key cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] req_addr;
  logic [7:0]  meta0;
  logic [7:0]  meta1;
  logic        mem_data_valid;
  logic [63:0] set_enable;
  logic [7:0]  meta_din;
  logic        meta_write0;
  logic        meta_write1;
  logic        hit;
  logic        hit_way;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        data_write;
  logic        data_way;
  logic [2:0]  word_sel;

  cache_fill_ctrl #(.MEM_LAT(4), .WORDS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_addr       (req_addr),
    .meta0          (meta0),
    .meta1          (meta1),
    .mem_data_valid (mem_data_valid),
    .set_enable     (set_enable),
    .meta_din       (meta_din),
    .meta_write0    (meta_write0),
    .meta_write1    (meta_write1),
    .hit            (hit),
    .hit_way        (hit_way),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .data_write     (data_write),
    .data_way       (data_way),
    .word_sel       (word_sel)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a miss in progress is described by how many words have
  // been requested and how many have come back.
  bit         m_fill, m_upd;
  int         m_iss, m_rcv;
  logic [5:0] m_tag, m_idx;
  logic       m_vic;

  // Memory model: requests seen in the last four cycles.
  logic [3:0] hist = 4'd0;
  logic       mreq_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    logic [63:0] e_set;
    logic [7:0]  e_din;
    logic [15:0] e_maddr;
    logic [2:0]  e_ws;
    logic        e_w0, e_w1, e_hit, e_hw, e_st, e_mr, e_dw, e_dway;
    logic [5:0]  rt;
    bit          m0, m1;
    e_set = 64'd0; e_din = 8'd0; e_maddr = 16'd0; e_ws = 3'd0;
    e_w0 = 0; e_w1 = 0; e_hit = 0; e_hw = 0; e_st = 0; e_mr = 0; e_dw = 0; e_dway = 0;
    rt = req_addr[15:10];
    m0 = meta0[7] && (meta0[5:0] == rt);
    m1 = meta1[7] && (meta1[5:0] == rt);
    if (!rst) begin
      m_fill = 0; m_upd = 0; m_iss = 0; m_rcv = 0; m_tag = 0; m_idx = 0; m_vic = 0;
    end
    if (m_fill) begin
      e_set  = 64'd1 << m_idx;
      e_st   = 1;
      e_dway = m_vic;
      if (m_iss < 8) begin
        e_mr    = 1;
        e_maddr = 16'(m_tag) * 16'd1024 + 16'(m_idx) * 16'd16 + 16'(m_iss) * 16'd2;
      end
      if (mem_data_valid) begin
        e_dw = 1;
        e_ws = 3'(m_rcv);
      end
    end else if (m_upd) begin
      e_set = 64'd1 << m_idx;
      e_st  = 1;
      e_din = 8'h80 + 8'(m_tag);
      e_w0  = (m_vic == 0);
      e_w1  = (m_vic == 1);
    end else begin
      e_set = 64'd1 << req_addr[9:4];
      if (rst && req) begin
        if (m0 || m1) begin
          e_hit = 1;
          e_hw  = m0 ? 1'b0 : 1'b1;
          e_w0  = 1;
          e_din = {meta0[7], (e_hw == 0), meta0[5:0]};
        end else begin
          e_st = 1;
        end
      end
    end
    chk("set_enable", set_enable, e_set);
    chk("meta_din", 64'(meta_din), 64'(e_din));
    chk("meta_write0", 64'(meta_write0), 64'(e_w0));
    chk("meta_write1", 64'(meta_write1), 64'(e_w1));
    chk("hit", 64'(hit), 64'(e_hit));
    chk("hit_way", 64'(hit_way), 64'(e_hw));
    chk("stall", 64'(stall), 64'(e_st));
    chk("mem_req", 64'(mem_req), 64'(e_mr));
    chk("mem_addr", 64'(mem_addr), 64'(e_maddr));
    chk("data_write", 64'(data_write), 64'(e_dw));
    chk("data_way", 64'(data_way), 64'(e_dway));
    chk("word_sel", 64'(word_sel), 64'(e_ws));
    // advance the model to the next cycle
    if (rst) begin
      if (m_fill) begin
        if (m_iss < 8) m_iss++;
        if (mem_data_valid) begin
          m_rcv++;
          if (m_rcv == 8) begin
            m_fill = 0;
            m_upd  = 1;
          end
        end
      end else if (m_upd) begin
        m_upd = 0;
      end else if (req && !(m0 || m1)) begin
        m_fill = 1;
        m_iss  = 0;
        m_rcv  = 0;
        m_tag  = rt;
        m_idx  = req_addr[9:4];
        m_vic  = !meta0[7] ? 1'b0 : !meta1[7] ? 1'b1 : meta0[6];
      end
    end
  endtask

  // One clock: compare at the falling edge, then move the memory pipeline
  // just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_cmp();
    mreq_seen = mem_req;
    @(posedge clk);
    #1;
    hist = {hist[2:0], mreq_seen};
    mem_data_valid = hist[3];
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; req_addr = 16'h1230; meta0 = 8'h00; meta1 = 8'h00;
    mem_data_valid = 1'b0;
    m_fill = 0; m_upd = 0; m_iss = 0; m_rcv = 0; m_tag = 0; m_idx = 0; m_vic = 0;

    // Reset state
    #1;
    chk("rst_set_enable", set_enable, 64'h0000_0008_0000_0000);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Cold miss on set 0x23, both ways invalid -> fill way 0
    req = 1'b1; req_addr = 16'h1230; meta0 = 8'h00; meta1 = 8'h00;
    #1;
    chk("miss_hit", 64'(hit), 64'd0);
    chk("miss_stall", 64'(stall), 64'd1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 14) meta0 = 8'h84;
      #1;
      if (c == 1)  begin chk("c1_mem_addr", 64'(mem_addr), 64'h1230); chk("c1_data_way", 64'(data_way), 64'd0); end
      if (c == 8)  chk("c8_mem_addr", 64'(mem_addr), 64'h123E);
      if (c == 9)  chk("c9_mem_req", 64'(mem_req), 64'd0);
      if (c == 5)  begin chk("c5_data_write", 64'(data_write), 64'd1); chk("c5_word_sel", 64'(word_sel), 64'd0); end
      if (c == 12) chk("c12_word_sel", 64'(word_sel), 64'd7);
      if (c == 13) begin chk("c13_meta_write0", 64'(meta_write0), 64'd1); chk("c13_meta_din", 64'(meta_din), 64'h84); end
      if (c == 14) begin chk("c14_hit", 64'(hit), 64'd1); chk("c14_meta_din", 64'(meta_din), 64'hC4); end
    end
    tick();

    // Hit in way 1: LRU flips to way 0 being LRU
    meta0 = 8'hC4; meta1 = 8'h85; req_addr = 16'h1630;
    #1;
    chk("w1_hit_way", 64'(hit_way), 64'd1);
    chk("w1_meta_din", 64'(meta_din), 64'h84);
    tick();

    // Both ways match: way 0 wins
    meta0 = 8'h84; meta1 = 8'h84; req_addr = 16'h1230;
    #1;
    chk("both_hit_way", 64'(hit_way), 64'd0);
    tick();

    // Both valid, way 1 LRU, miss on tag 9; req dropped and meta disturbed mid-fill
    meta0 = 8'hC4; meta1 = 8'h85; req_addr = 16'h2630;
    #1;
    chk("lru_miss_stall", 64'(stall), 64'd1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 3) req = 1'b0;
      if (c == 4) begin meta0 = 8'h89; meta1 = 8'h89; end
      if (c == 14) begin req = 1'b1; meta0 = 8'hC4; meta1 = 8'h89; end
      #1;
      if (c == 1)  chk("lru_data_way", 64'(data_way), 64'd1);
      if (c == 13) begin
        chk("lru_meta_write1", 64'(meta_write1), 64'd1);
        chk("lru_meta_din", 64'(meta_din), 64'h89);
      end
      if (c == 14) chk("lru_rehit_way", 64'(hit_way), 64'd1);
    end
    tick();

    // Reset in the middle of a fill
    meta0 = 8'h00; meta1 = 8'h00; req_addr = 16'h1230;
    for (int c = 1; c <= 6; c++) tick();
    rst = 1'b0; hist = 4'd0; mem_data_valid = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_set_enable", set_enable, 64'h0000_0008_0000_0000);
    tick();
    rst = 1'b1;
    #1;
    chk("restart_stall", 64'(stall), 64'd1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 14) meta0 = 8'h84;
      #1;
      if (c == 1)  chk("restart_mem_addr", 64'(mem_addr), 64'h1230);
      if (c == 5)  chk("restart_word_sel", 64'(word_sel), 64'd0);
      if (c == 13) chk("restart_meta_din", 64'(meta_din), 64'h84);
    end
    tick();

    // Stray memory valid while idle
    req = 1'b0;
    tick();
    mem_data_valid = 1'b1;
    #1;
    chk("idle_valid_dw", 64'(data_write), 64'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
